// File: rtl/driver_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : driver_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter with a TX FIFO on the DLX bus.
// Revision : 1.0 - initial release
// ============================================================================
module driver_uart_tx #(
    parameter int FIFO_DEPTH      = 16,
    parameter int DEFAULT_DIVISOR = 433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chip_select,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        rdata_valid,
    output logic        tx,
    output logic        busy
);

    localparam int         c_PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [1:0] c_REG_TXDATA  = 2'd0;
    localparam logic [1:0] c_REG_STATUS  = 2'd1;
    localparam logic [1:0] c_REG_DIVISOR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_level;
    logic               r_overflow;
    logic [15:0]        r_divisor;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_div_cnt;
    logic [15:0]        w_div_cnt_nxt;
    logic [15:0]        r_frame_div;
    logic [15:0]        w_frame_div_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_tx;
    logic               w_tx_nxt;

    logic [31:0]        r_data_read;
    logic               r_rdata_valid;
    logic [31:0]        w_rdata;

    logic               w_sel_wr;
    logic               w_sel_rd;
    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_bit_done;
    logic               w_unused;

    assign w_sel_wr   = chip_select && write_enable;
    assign w_sel_rd   = chip_select && !write_enable;
    assign w_full     = (r_level == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_push_req = w_sel_wr && (address[3:2] == c_REG_TXDATA);
    assign w_push     = w_push_req && !w_full;
    assign w_bit_done = (r_div_cnt == r_frame_div);
    assign w_unused   = &{1'b0, address[31:4], address[1:0], data_write[31:16]};

    // FIFO storage needs no reset: only entries below the level are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_write[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_divisor  <= 16'(DEFAULT_DIVISOR);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Full is judged before this cycle's pop, so a dropped push still flags overflow.
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_sel_wr && (address[3:2] == c_REG_STATUS) && data_write[3]) begin
                r_overflow <= 1'b0;
            end
            if (w_sel_wr && (address[3:2] == c_REG_DIVISOR)) begin
                r_divisor <= data_write[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_frame_div <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_frame_div <= w_frame_div_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_tx        <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_cnt_nxt   = r_div_cnt;
        w_frame_div_nxt = r_frame_div;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_pop           = 1'b0;
        w_tx_nxt        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_shift_nxt     = r_mem[r_rd_ptr];
                    w_frame_div_nxt = r_divisor;
                    w_div_cnt_nxt   = '0;
                    w_state_nxt     = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_div_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = ST_DATA;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_div_cnt_nxt = '0;
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_div_cnt_nxt = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!w_empty) begin
                        w_pop           = 1'b1;
                        w_shift_nxt     = r_mem[r_rd_ptr];
                        w_frame_div_nxt = r_divisor;
                        w_state_nxt     = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (address[3:2])
            c_REG_STATUS: begin
                w_rdata[0]    = busy;
                w_rdata[1]    = w_full;
                w_rdata[2]    = w_empty;
                w_rdata[3]    = r_overflow;
                w_rdata[15:8] = 8'(r_level);
            end
            c_REG_DIVISOR: w_rdata[15:0] = r_divisor;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_read   <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_sel_rd;
            if (w_sel_rd) begin
                r_data_read <= w_rdata;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE) || !w_empty;
    assign tx          = r_tx;
    assign data_read   = r_data_read;
    assign rdata_valid = r_rdata_valid;

endmodule
`default_nettype wire

// File: tb/tb_driver_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_driver_uart_tx
// Purpose  : Self-checking bench for driver_uart_tx (bus registers and tx line).
// Revision : 1.0 - initial release
// ============================================================================
module tb_driver_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        chip_select;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        rdata_valid;
    logic        tx;
    logic        busy;

    driver_uart_tx #(
        .FIFO_DEPTH      (16),
        .DEFAULT_DIVISOR (433)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .chip_select  (chip_select),
        .write_enable (write_enable),
        .address      (address),
        .data_write   (data_write),
        .data_read    (data_read),
        .rdata_valid  (rdata_valid),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expv;
    } vec_t;

    frame_t exp_q[$];
    int     starts[$];
    logic   mon_active = 1'b0;
    frame_t mon_frame;
    int     mon_k;
    int     mon_bad_k;
    logic   mon_bad_v;
    int     last_wr_cyc;
    logic [31:0] last_rd = 32'h0;

    // Line level of a frame at bit-clock k: start 0, data LSB first, stop 1.
    function automatic logic exp_bit(frame_t f, int k);
        int idx;
        idx = k / (f.div + 1);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return f.data[idx-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic mon_step();
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_frame: tx=0 at cycle %0d, expected idle 1", cyc);
                end else begin
                    mon_frame  = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_k      = 0;
                    mon_bad_k  = -1;
                    starts.push_back(cyc);
                end
            end
            if (mon_active) begin
                if (tx !== exp_bit(mon_frame, mon_k) && mon_bad_k < 0) begin
                    mon_bad_k = mon_k;
                    mon_bad_v = tx;
                end
                mon_k++;
                if (mon_k == 10 * (mon_frame.div + 1)) begin
                    mon_active = 1'b0;
                    n_checks++;
                    if (mon_bad_k >= 0) begin
                        n_err++;
                        $display("FAIL frame_%02h: tx=%b at bit-clock %0d, expected %b (div %0d)",
                                 mon_frame.data, mon_bad_v, mon_bad_k,
                                 exp_bit(mon_frame, mon_bad_k), mon_frame.div);
                    end
                end
            end
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chip_select  = 1'b1;
        write_enable = 1'b1;
        address      = {28'h0, a, 2'b00};
        data_write   = d;
        @(negedge clk);
        last_wr_cyc  = cyc;
        chip_select  = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] expv);
        chip_select  = 1'b1;
        write_enable = 1'b0;
        address      = {28'h0, a, 2'b00};
        @(negedge clk);
        chip_select  = 1'b0;
        check({name, "_valid"}, {31'h0, rdata_valid}, 32'h1);
        check(name, data_read, expv);
        last_rd = expv;
    endtask

    task automatic wait_idle(input string name, input int budget, output int t_idle);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        t_idle = cyc;
        n_checks++;
        if (busy || exp_q.size() != 0 || mon_active) begin
            n_err++;
            $display("FAIL %s_timeout: busy=%b pending=%0d after %0d cycles, expected idle",
                     name, busy, exp_q.size(), budget);
        end
    endtask

    function automatic int get_start(input int i);
        if (i < starts.size()) return starts[i];
        return -1000;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[11];
        int          t;
        int          base;
        int          wr;
        int          n0;
        int          d;
        int          nb;
        logic [7:0]  b;

        vecs[0]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[2]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_01B1};
        vecs[3]  = '{1'b1, 2'd2, 32'hABCD_1234, 32'h0000_0000};
        vecs[4]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_1234};
        vecs[5]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6]  = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000};
        vecs[7]  = '{1'b1, 2'd1, 32'hFFFF_FFF7, 32'h0000_0000};
        vecs[8]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_0004};
        vecs[9]  = '{1'b1, 2'd2, 32'hFFFF_0003, 32'h0000_0000};
        vecs[10] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_0003};

        reset        = 1'b1;
        chip_select  = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        data_write   = '0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (2) @(negedge clk);
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_rvalid", {31'h0, rdata_valid}, 32'h0);
        check("reset_rdata", data_read, 32'h0);
        reset = 1'b0;

        @(negedge clk);
        check("valid_idle", {31'h0, rdata_valid}, 32'h0);
        read_check("status_after_reset", 2'd1, 32'h0000_0004);
        @(negedge clk);
        check("valid_pulse_end", {31'h0, rdata_valid}, 32'h0);
        check("rdata_hold", data_read, 32'h0000_0004);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
                check($sformatf("vec%0d_wr_valid", i), {31'h0, rdata_valid}, 32'h0);
                check($sformatf("vec%0d_wr_hold", i), data_read, last_rd);
            end else begin
                read_check($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].expv);
            end
        end

        // Single 0x55 frame at 4 clocks per bit.
        exp_q.push_back('{8'h55, 3});
        base = starts.size();
        bus_write(2'd0, 32'hFFFF_FF55);
        wr = last_wr_cyc;
        wait_idle("frame55", 300, t);
        check("start_latency", 32'(get_start(base) - wr), 32'd1);
        check("busy_drop", 32'(t - get_start(base)), 32'd40);

        // Two back-to-back frames at 1 clock per bit.
        bus_write(2'd2, 32'h0);
        exp_q.push_back('{8'hA5, 0});
        exp_q.push_back('{8'h3C, 0});
        base = starts.size();
        bus_write(2'd0, 32'h0000_00A5);
        bus_write(2'd0, 32'h0000_003C);
        wait_idle("b2b", 100, t);
        check("b2b_gap", 32'(get_start(base + 1) - get_start(base)), 32'd10);
        check("b2b_total", 32'(t - get_start(base)), 32'd20);

        // 18 writes: one goes straight to the shifter, 16 fill the FIFO, the last is dropped.
        bus_write(2'd2, 32'd3);
        for (int j = 0; j < 18; j++) begin
            b = 8'($urandom);
            if (j < 17) exp_q.push_back('{b, 3});
            bus_write(2'd0, {24'($urandom), b});
        end
        read_check("status_full_ovf", 2'd1, 32'h0000_100B);
        bus_write(2'd1, 32'h0000_0008);
        read_check("status_ovf_clr", 2'd1, 32'h0000_1003);
        wait_idle("fifo_drain", 17 * 40 + 200, t);
        read_check("status_drained", 2'd1, 32'h0000_0004);

        // Divisor change mid-frame only affects the following frame.
        bus_write(2'd2, 32'd1);
        exp_q.push_back('{8'hC3, 1});
        exp_q.push_back('{8'h96, 7});
        base = starts.size();
        bus_write(2'd0, 32'h0000_00C3);
        bus_write(2'd0, 32'h0000_0096);
        repeat (2) @(negedge clk);
        bus_write(2'd2, 32'd7);
        read_check("divisor_rd7", 2'd2, 32'h0000_0007);
        wait_idle("div_change", 300, t);
        check("div_change_gap", 32'(get_start(base + 1) - get_start(base)), 32'd20);

        // Randomised rounds against the frame model.
        for (int r = 0; r < 8; r++) begin
            d  = $urandom_range(0, 3);
            nb = $urandom_range(1, 4);
            bus_write(2'd2, 32'(d));
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                exp_q.push_back('{b, d});
                bus_write(2'd0, {24'($urandom), b});
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
            wait_idle($sformatf("rand%0d", r), nb * 60 + 200, t);
            read_check($sformatf("rand%0d_status", r), 2'd1, 32'h0000_0004);
        end

        // Reset in the middle of a data bit with three bytes queued.
        bus_write(2'd2, 32'd3);
        for (int j = 0; j < 4; j++) begin
            b = 8'($urandom);
            exp_q.push_back('{b, 3});
            bus_write(2'd0, {24'h0, b});
        end
        repeat (8) @(negedge clk);
        read_check("pre_reset_status", 2'd1, 32'h0000_0301);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_async_tx", {31'h0, tx}, 32'h1);
        check("reset_async_busy", {31'h0, busy}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        read_check("post_reset_status", 2'd1, 32'h0000_0004);
        read_check("post_reset_divisor", 2'd2, 32'h0000_01B1);
        n0 = starts.size();
        repeat (200) @(negedge clk);
        check("no_frame_after_reset", 32'(starts.size()), 32'(n0));
        check("tx_idle_after_reset", {31'h0, tx}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
